// File: rtl/gpio_cfg_pkg.sv
// Shared constants and types for the GPIO configuration shifter.
//   CFG_WIDTH        bits per pad control block
//   *_IDX / DM_*     bit positions of each field inside a pad word
//   DEFAULT_PAD_CFG  power-on pad configuration word
//   state_e          transfer FSM states
//   max_u            elaboration-time maximum helper
package gpio_cfg_pkg;

  localparam int unsigned CFG_WIDTH = 13;

  localparam int unsigned MGMT_ENA_IDX    = 0;
  localparam int unsigned OUTENB_IDX      = 1;
  localparam int unsigned HOLDOVER_IDX    = 2;
  localparam int unsigned INP_DIS_IDX     = 3;
  localparam int unsigned IB_MODE_SEL_IDX = 4;
  localparam int unsigned ANALOG_EN_IDX   = 5;
  localparam int unsigned ANALOG_SEL_IDX  = 6;
  localparam int unsigned ANALOG_POL_IDX  = 7;
  localparam int unsigned SLOW_SEL_IDX    = 8;
  localparam int unsigned VTRIP_SEL_IDX   = 9;
  localparam int unsigned DM_LSB          = 10;
  localparam int unsigned DM_MSB          = 12;

  localparam logic [CFG_WIDTH-1:0] DEFAULT_PAD_CFG = 13'h1803;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpio_cfg_bit_timer.sv
// Serial-clock phase timer: counts CLK_DIV system cycles per half period,
// tracks which half of the bit period is active, and counts bit periods.
//   clk, rst        system clock, synchronous active-high reset
//   clr_i           return to count 0, low half, bit 0
//   en_i            advance the phase counter
//   tick_c          last cycle of the current half period
//   period_end_c    last cycle of a full (low+high) bit period
//   last_bit_c      current bit period is bit NBITS-1
module gpio_cfg_bit_timer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NBITS   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c,
  output logic period_end_c,
  output logic last_bit_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  // Flags come from registers only so the FSM can use them without a loop.
  always_comb begin : flags
    tick_c       = (cnt_q == CNT_W'(CLK_DIV - 1));
    period_end_c = tick_c && half_q;
    last_bit_c   = (bit_q == BIT_W'(NBITS - 1));
  end

  always_comb begin : next_count
    cnt_d  = cnt_q;
    half_d = half_q;
    bit_d  = bit_q;
    if (clr_i) begin
      cnt_d  = '0;
      half_d = 1'b0;
      bit_d  = '0;
    end else if (en_i) begin
      if (tick_c) begin
        cnt_d  = '0;
        half_d = ~half_q;
        if (half_q) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/gpio_cfg_shifter.sv
// Serial configuration transmitter for the user-project GPIO pad ring.
// Captures a flat per-pad configuration word, shifts it MSB-first into the
// two pad control-block chains on a divided serial clock, then strobes load.
//   wb_clk_i, wb_rst_i   system clock, synchronous active-high reset
//   start                request a transfer (honoured only when idle)
//   cfg_i                pad p config at [p*CFG_WIDTH +: CFG_WIDTH]
//   busy, done           transfer in progress / one-cycle completion pulse
//   serial_clock         chain shift clock
//   serial_load          chain latch strobe
//   serial_resetn        chain reset, active low
//   serial_data_1/2      chain 1 / chain 2 data
module gpio_cfg_shifter #(
  parameter int unsigned AREA1PADS  = 19,
  parameter int unsigned TOTAL_PADS = 38,
  parameter int unsigned CFG_WIDTH  = gpio_cfg_pkg::CFG_WIDTH,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            start,
  input  logic [TOTAL_PADS*CFG_WIDTH-1:0] cfg_i,
  output logic                            busy,
  output logic                            done,
  output logic                            serial_clock,
  output logic                            serial_load,
  output logic                            serial_resetn,
  output logic                            serial_data_1,
  output logic                            serial_data_2
);
  import gpio_cfg_pkg::*;

  localparam int unsigned AREA2PADS = TOTAL_PADS - AREA1PADS;
  localparam int unsigned SPADS     = max_u(AREA1PADS, AREA2PADS);
  localparam int unsigned NBITS     = SPADS * CFG_WIDTH;
  localparam int unsigned CH1_W     = AREA1PADS * CFG_WIDTH;
  localparam int unsigned CH2_W     = AREA2PADS * CFG_WIDTH;

  state_e           state_q, state_d;
  logic [NBITS-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [NBITS-1:0] sh2_init_c;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sclk_q, sclk_d, sload_q, sload_d, sresetn_q, sresetn_d;
  logic             sdata1_q, sdata1_d, sdata2_q, sdata2_d;
  logic             timer_en_c, timer_clr_c;
  logic             tick_c, period_end_c, last_bit_c;

  // Chain 2 goes out lowest pad first, so pad words are reversed into the
  // shadow; any shortfall versus the longer chain becomes leading zeros.
  for (genvar g = 0; g < AREA2PADS; g++) begin : g_ch2
    assign sh2_init_c[(AREA2PADS-1-g)*CFG_WIDTH +: CFG_WIDTH] =
      cfg_i[(AREA1PADS+g)*CFG_WIDTH +: CFG_WIDTH];
  end
  if (NBITS > CH2_W) begin : g_ch2_lead
    assign sh2_init_c[NBITS-1:CH2_W] = '0;
  end

  gpio_cfg_bit_timer #(
    .CLK_DIV (CLK_DIV),
    .NBITS   (NBITS)
  ) u_timer (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .clr_i        (timer_clr_c),
    .en_i         (timer_en_c),
    .tick_c       (tick_c),
    .period_end_c (period_end_c),
    .last_bit_c   (last_bit_c)
  );

  // Next state, shadow shifting, and next output values.
  always_comb begin : next_state
    state_d    = state_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    timer_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CRST;
          sh1_d   = NBITS'(cfg_i[CH1_W-1:0]);
          sh2_d   = sh2_init_c;
        end
      end
      ST_CRST: begin
        timer_en_c = 1'b1;
        if (period_end_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        timer_en_c = 1'b1;
        if (period_end_c) begin
          if (last_bit_c) begin
            state_d = ST_LOAD;
          end else begin
            sh1_d = sh1_q << 1;
            sh2_d = sh2_q << 1;
          end
        end
      end
      ST_LOAD: begin
        timer_en_c = 1'b1;
        if (tick_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Each phase restarts the timer from zero.
    timer_clr_c = !timer_en_c || (state_d != state_q);

    busy_d    = (state_d == ST_CRST) || (state_d == ST_SHIFT) || (state_d == ST_LOAD);
    done_d    = (state_d == ST_DONE);
    sload_d   = (state_d == ST_LOAD);
    sresetn_d = (state_d != ST_CRST);
    // The serial clock mirrors the timer's half-period flag while shifting.
    sclk_d    = (state_q == ST_SHIFT) && (state_d == ST_SHIFT) && (sclk_q ^ tick_c);
    sdata1_d  = (state_d == ST_SHIFT) && sh1_d[NBITS-1];
    sdata2_d  = (state_d == ST_SHIFT) && sh2_d[NBITS-1];
  end

  always_ff @(posedge wb_clk_i) begin : regs
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      sh1_q     <= '0;
      sh2_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sload_q   <= 1'b0;
      sresetn_q <= 1'b0;
      sdata1_q  <= 1'b0;
      sdata2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sload_q   <= sload_d;
      sresetn_q <= sresetn_d;
      sdata1_q  <= sdata1_d;
      sdata2_q  <= sdata2_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = sload_q;
  assign serial_resetn = sresetn_q;
  assign serial_data_1 = sdata1_q;
  assign serial_data_2 = sdata2_q;

endmodule

// File: tb/tb_gpio_cfg_shifter.sv
// Bench for gpio_cfg_shifter: a default-sized instance (19/38 pads, D=4) and a
// small unequal-chain instance (5/8 pads, D=1). A chain model of 13-bit pad
// registers captures what the pads would latch; a scoreboard compares it on done.
module tb_gpio_cfg_shifter;

  localparam int unsigned W    = 13;
  localparam int unsigned MAXP = 38;
  localparam int unsigned CFGB = MAXP * W;

  typedef struct {
    logic [CFGB-1:0] cfg;
    int unsigned     done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst0, rst1, start0, start1;
  logic [CFGB-1:0] cfg0;
  logic [8*W-1:0]  cfg1;
  logic [1:0]      busy, done, sclk, sload, sresetn, sd1, sd2;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t expq [2][$];

  gpio_cfg_shifter #(.AREA1PADS(19), .TOTAL_PADS(38), .CFG_WIDTH(13), .CLK_DIV(4)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst0), .start(start0), .cfg_i(cfg0),
    .busy(busy[0]), .done(done[0]), .serial_clock(sclk[0]), .serial_load(sload[0]),
    .serial_resetn(sresetn[0]), .serial_data_1(sd1[0]), .serial_data_2(sd2[0]));

  gpio_cfg_shifter #(.AREA1PADS(5), .TOTAL_PADS(8), .CFG_WIDTH(13), .CLK_DIV(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst1), .start(start1), .cfg_i(cfg1),
    .busy(busy[1]), .done(done[1]), .serial_clock(sclk[1]), .serial_load(sload[1]),
    .serial_resetn(sresetn[1]), .serial_data_1(sd1[1]), .serial_data_2(sd2[1]));

  function automatic int a1_of(input int d);  return (d == 0) ? 19 : 5; endfunction
  function automatic int tot_of(input int d); return (d == 0) ? 38 : 8; endfunction
  function automatic int div_of(input int d); return (d == 0) ? 4 : 1;  endfunction
  function automatic int nbits_of(input int d);
    int a1, a2;
    a1 = a1_of(d);
    a2 = tot_of(d) - a1;
    return ((a1 > a2) ? a1 : a2) * W;
  endfunction
  function automatic int busy_len_of(input int d);
    return div_of(d) * (2 * nbits_of(d) + 3);
  endfunction

  // Bit idx (0 = first sent) expected on chain ch: leading zeros, then pad words MSB first.
  function automatic logic exp_bit(input int d, input logic [CFGB-1:0] c, input int ch, input int idx);
    int a1, len, lead, j, b, pad;
    a1   = a1_of(d);
    len  = (ch == 1) ? a1 : tot_of(d) - a1;
    lead = nbits_of(d) - len * W;
    if (idx < lead) return 1'b0;
    j   = (idx - lead) / W;
    b   = W - 1 - ((idx - lead) % W);
    pad = (ch == 1) ? (a1 - 1 - j) : (a1 + j);
    return c[pad*W + b];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- chain model + monitor ----------------
  logic [W-1:0] creg   [2][MAXP];
  logic [W-1:0] latchv [2][MAXP];
  bit           s1     [2][256];
  bit           s2     [2][256];
  int           n1 [2], n2 [2], bcnt [2], ldcnt [2], viol [2];
  logic         psclk [2], pload [2], pd1 [2], pd2 [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      n1[d] = 0; n2[d] = 0; bcnt[d] = 0; ldcnt[d] = 0; viol[d] = 0;
      psclk[d] = 1'b0; pload[d] = 1'b0; pd1[d] = 1'b0; pd2[d] = 1'b0;
      for (int p = 0; p < MAXP; p++) begin
        creg[d][p] = '0; latchv[d][p] = '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   a1, tot, nb, bad;
      logic r;
      exp_t e;
      a1  = a1_of(d);
      tot = tot_of(d);
      nb  = nbits_of(d);
      r   = (d == 0) ? rst0 : rst1;
      if (r) begin
        bcnt[d] = 0; ldcnt[d] = 0; viol[d] = 0;
      end
      if (!sresetn[d]) begin
        for (int p = 0; p < MAXP; p++) creg[d][p] = '0;
        n1[d] = 0; n2[d] = 0;
      end else if (sclk[d] && !psclk[d]) begin
        if (n1[d] < 256) s1[d][n1[d]] = sd1[d];
        if (n2[d] < 256) s2[d][n2[d]] = sd2[d];
        n1[d]++; n2[d]++;
        for (int p = a1 - 1; p > 0; p--) creg[d][p] = {creg[d][p][W-2:0], creg[d][p-1][W-1]};
        creg[d][0] = {creg[d][0][W-2:0], sd1[d]};
        for (int p = a1; p < tot - 1; p++) creg[d][p] = {creg[d][p][W-2:0], creg[d][p+1][W-1]};
        creg[d][tot-1] = {creg[d][tot-1][W-2:0], sd2[d]};
      end
      if (psclk[d] && sclk[d] && (sd1[d] != pd1[d] || sd2[d] != pd2[d])) viol[d]++;
      if (sload[d] && sclk[d]) viol[d]++;
      if (sload[d] && !pload[d]) begin
        chk($sformatf("load_pending%0d", d), longint'(expq[d].size() > 0), 1);
        for (int p = 0; p < MAXP; p++) latchv[d][p] = creg[d][p];
      end
      if (sload[d]) ldcnt[d]++;
      if (busy[d])  bcnt[d]++;
      if (done[d]) begin
        chk($sformatf("done_pending%0d", d), longint'(expq[d].size() > 0), 1);
        if (expq[d].size() > 0) begin
          e = expq[d].pop_front();
          chk($sformatf("done_cycle%0d", d), cyc, e.done_cyc);
          chk($sformatf("busy_len%0d", d), bcnt[d], busy_len_of(d));
          chk($sformatf("busy_at_done%0d", d), busy[d], 0);
          chk($sformatf("load_len%0d", d), ldcnt[d], div_of(d));
          chk($sformatf("phase_viol%0d", d), viol[d], 0);
          chk($sformatf("ch1_nbits%0d", d), n1[d], nb);
          chk($sformatf("ch2_nbits%0d", d), n2[d], nb);
          bad = -1;
          for (int i = nb - 1; i >= 0; i--) if (i < 256 && s1[d][i] != exp_bit(d, e.cfg, 1, i)) bad = i;
          chk($sformatf("ch1_stream_first_bad_bit%0d", d), bad, -1);
          bad = -1;
          for (int i = nb - 1; i >= 0; i--) if (i < 256 && s2[d][i] != exp_bit(d, e.cfg, 2, i)) bad = i;
          chk($sformatf("ch2_stream_first_bad_bit%0d", d), bad, -1);
          for (int p = 0; p < tot; p++)
            chk($sformatf("dut%0d_pad%0d_cfg", d, p), latchv[d][p], e.cfg[p*W +: W]);
        end
        bcnt[d] = 0; ldcnt[d] = 0; viol[d] = 0;
      end
      psclk[d] = sclk[d]; pload[d] = sload[d]; pd1[d] = sd1[d]; pd2[d] = sd2[d];
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_xfer(input int d, input logic [CFGB-1:0] c);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin cfg0 = c; start0 = 1'b1; end
    else        begin cfg1 = c[8*W-1:0]; start1 = 1'b1; end
    e.cfg      = c;
    e.done_cyc = cyc + 1 + busy_len_of(d);
    expq[d].push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget && expq[d].size() != 0; i++) @(negedge clk);
    chk($sformatf("done_timeout%0d", d), expq[d].size(), 0);
    expq[d].delete();
  endtask

  task automatic check_outs(input int d, input logic [6:0] exp, input string name);
    logic [6:0] act;
    act = {busy[d], done[d], sclk[d], sload[d], sresetn[d], sd1[d], sd2[d]};
    chk(name, act, exp);
  endtask

  function automatic logic [CFGB-1:0] rand_cfg(input int d);
    logic [CFGB-1:0] c;
    c = '0;
    for (int p = 0; p < tot_of(d); p++) c[p*W +: W] = W'($urandom);
    return c;
  endfunction

  localparam logic [6:0] RST_OUTS  = 7'b0000000;
  localparam logic [6:0] IDLE_OUTS = 7'b0000100;

  initial begin
    logic [CFGB-1:0] c;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    cfg0 = '0;   cfg1 = '0;
    repeat (3) @(negedge clk);
    check_outs(0, RST_OUTS, "reset_values0");
    check_outs(1, RST_OUTS, "reset_values1");
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check_outs(0, IDLE_OUTS, "idle_after_reset0");
    check_outs(1, IDLE_OUTS, "idle_after_reset1");

    // Uniform default configuration, then pad p = p+1 ordering, on both instances.
    for (int d = 0; d < 2; d++) begin
      c = '0;
      for (int p = 0; p < tot_of(d); p++) c[p*W +: W] = 13'h1803;
      start_xfer(d, c);
      wait_done(d, busy_len_of(d) + 50);
      c = '0;
      for (int p = 0; p < tot_of(d); p++) c[p*W +: W] = W'(p + 1);
      start_xfer(d, c);
      wait_done(d, busy_len_of(d) + 50);
    end

    // Random configurations.
    for (int i = 0; i < 4; i++) begin
      start_xfer(1, rand_cfg(1));
      wait_done(1, busy_len_of(1) + 50);
    end
    start_xfer(0, rand_cfg(0));
    wait_done(0, busy_len_of(0) + 50);

    // cfg_i change and a second start while busy must both be ignored.
    start_xfer(0, rand_cfg(0));
    repeat (48) @(negedge clk);
    cfg0 = '0;
    repeat (50) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, busy_len_of(0) + 50);
    repeat (20) @(negedge clk);
    check_outs(0, IDLE_OUTS, "idle_after_ignored_start");

    // Reset mid-shift aborts without load or done; next transfer is complete.
    start_xfer(0, rand_cfg(0));
    repeat (499) @(negedge clk);
    rst0 = 1'b1;
    expq[0].delete();
    @(negedge clk);
    check_outs(0, RST_OUTS, "abort_reset_values");
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    check_outs(0, IDLE_OUTS, "idle_after_abort");
    start_xfer(0, rand_cfg(0));
    wait_done(0, busy_len_of(0) + 50);

    // Start together with reset: reset wins, no transfer follows.
    @(negedge clk);
    rst1 = 1'b1; start1 = 1'b1; cfg1 = '1;
    @(negedge clk);
    start1 = 1'b0;
    check_outs(1, RST_OUTS, "reset_beats_start");
    rst1 = 1'b0;
    repeat (5) @(negedge clk);
    check_outs(1, IDLE_OUTS, "idle_no_transfer");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
